// File: rtl/wdt_reset_defs.sv
// rtl/wdt_reset_defs.sv - shared state encodings and cause bit indices for wdt_reset_gen
package wdt_reset_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'h0,
    ASSERT = 2'h1,
    SETTLE = 2'h2
  } wdt_state_e;

  localparam int CAUSE_WDT = 0;
  localparam int CAUSE_SW  = 1;

endpackage

// File: rtl/wdt_reset_gen.sv
// rtl/wdt_reset_gen.sv - stretched system reset from watchdog timeout or software request; optional WDT_RESET_COUNT_EN
module wdt_reset_gen
  import wdt_reset_defs::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wdt_timeout,
  input  logic       sw_reset_req,
  input  logic       cause_clear,
  output logic       sys_reset_n,
  output logic       wdt_stop,
  output logic       busy,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count
);

  localparam logic [7:0] RESET_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  wdt_state_e state_q, state_d;
  logic [7:0] ctr_q, ctr_d;
  logic [1:0] cause_q, cause_d;
  logic       sys_reset_n_q;
  logic       wdt_stop_q;
  logic       busy_q;
  logic       trigger;

  // Triggers are only accepted from IDLE; ASSERT and SETTLE ignore them.
  assign trigger = (state_q == IDLE) && (wdt_timeout || sw_reset_req);

  // Next state, hold counter and sticky cause; a same-cycle set overrides the clear.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cause_d = cause_clear ? 2'b00 : cause_q;
    case (state_q)
      IDLE: begin
        ctr_d = 8'd0;
        if (trigger) state_d = ASSERT;
        if (wdt_timeout) cause_d[CAUSE_WDT] = 1'b1;
        if (sw_reset_req) cause_d[CAUSE_SW] = 1'b1;
      end
      ASSERT: begin
        if (ctr_q == RESET_LAST) begin
          state_d = SETTLE;
          ctr_d   = 8'd0;
        end else begin
          ctr_d = ctr_q + 8'd1;
        end
      end
      SETTLE: begin
        // A timeout still asserted keeps the watchdog stopped instead of retriggering.
        if (ctr_q == SETTLE_LAST && !wdt_timeout) begin
          state_d = IDLE;
          ctr_d   = 8'd0;
        end else if (ctr_q != SETTLE_LAST) begin
          ctr_d = ctr_q + 8'd1;
        end
      end
      default: begin
        state_d = ASSERT;
        ctr_d   = 8'd0;
      end
    endcase
  end

  // State, counter and cause registers; reset lands in ASSERT for the power-on hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ASSERT;
      ctr_q   <= 8'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      cause_q <= cause_d;
    end
  end

  // Outputs are registered from the next-state decode so they track state_q without glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset_n_q <= 1'b0;
      wdt_stop_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      sys_reset_n_q <= (state_d != ASSERT);
      wdt_stop_q    <= (state_d == SETTLE);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign sys_reset_n = sys_reset_n_q;
  assign wdt_stop    = wdt_stop_q;
  assign busy        = busy_q;
  assign reset_cause = cause_q;

`ifdef WDT_RESET_COUNT_EN
  logic [7:0] count_q, count_d;

  // Saturating count of watchdog-caused resets; an increment beats a same-cycle clear.
  always_comb begin
    count_d = cause_clear ? 8'd0 : count_q;
    if ((state_q == IDLE) && wdt_timeout && (count_d != 8'hff)) count_d = count_d + 8'd1;
  end

  // Reset count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= 8'd0;
    else          count_q <= count_d;
  end

  assign reset_count = count_q;
`else
  assign reset_count = 8'h00;
`endif

endmodule

// File: tb/tb_wdt_reset_gen.sv
// tb/tb_wdt_reset_gen.sv - directed self-checking bench for wdt_reset_gen
module tb_wdt_reset_gen;

`ifdef WDT_RESET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wdt_timeout;
  logic       sw_reset_req;
  logic       cause_clear;
  logic       sys_reset_n;
  logic       wdt_stop;
  logic       busy;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [7:0] exp_count = 8'd0;

  wdt_reset_gen #(.RESET_CYCLES(16), .SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wdt_timeout  (wdt_timeout),
    .sw_reset_req (sw_reset_req),
    .cause_clear  (cause_clear),
    .sys_reset_n  (sys_reset_n),
    .wdt_stop     (wdt_stop),
    .busy         (busy),
    .reset_cause  (reset_cause),
    .reset_count  (reset_count)
  );

  always #5 clk = ~clk;

  // Samples once per negedge until busy drops, counting low-reset and stop cycles.
  // drop_at: stop-cycle count at which wdt_timeout is released.
  // pulse_at: low-cycle count at which sw_reset_req and wdt_timeout pulse for one cycle (-1 = none).
  task automatic wait_idle(input int drop_at, input int pulse_at,
                           output int low_cnt, output int stop_cnt, output bit to);
    low_cnt  = 0;
    stop_cnt = 0;
    to       = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!sys_reset_n) low_cnt++;
      if (wdt_stop) stop_cnt++;
      if (!busy) begin
        to = 1'b0;
        break;
      end
      if (stop_cnt == drop_at) wdt_timeout = 1'b0;
      if (pulse_at >= 0) begin
        sw_reset_req = (low_cnt == pulse_at);
        wdt_timeout  = (low_cnt == pulse_at);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lo, st;
    bit to;
    check_cnt++; if (sys_reset_n !== 1'b0) $display("FAIL rst_sys_reset_n got %b exp 0", sys_reset_n); else pass_cnt++;
    check_cnt++; if (wdt_stop !== 1'b0) $display("FAIL rst_wdt_stop got %b exp 0", wdt_stop); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy got %b exp 1", busy); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b00) $display("FAIL rst_cause got %b exp 00", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== 8'd0) $display("FAIL rst_count got %0d exp 0", reset_count); else pass_cnt++;
    reset_n = 1'b1;
    wait_idle(0, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL por_timeout got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL por_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (st != 4) $display("FAIL por_stop got %0d exp 4", st); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b00) $display("FAIL por_cause got %b exp 00", reset_cause); else pass_cnt++;
    check_cnt++; if (sys_reset_n !== 1'b1 || wdt_stop !== 1'b0) $display("FAIL por_idle_outs got %b%b exp 10", sys_reset_n, wdt_stop); else pass_cnt++;
  endtask

  task automatic test_wdt_timeout();
    int lo, st;
    bit to;
    wdt_timeout = 1'b1;
    @(negedge clk);
    if (CNT_EN) exp_count = exp_count + 8'd1;
    check_cnt++; if (sys_reset_n !== 1'b0) $display("FAIL wdt_latency got %b exp 0", sys_reset_n); else pass_cnt++;
    wait_idle(3, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL wdt_timeout_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL wdt_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (st != 4) $display("FAIL wdt_stop_cycles got %0d exp 4", st); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b01) $display("FAIL wdt_cause got %b exp 01", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL wdt_count got %0d exp %0d", reset_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_both_triggers();
    int lo, st;
    bit to;
    wdt_timeout  = 1'b1;
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    if (CNT_EN) exp_count = exp_count + 8'd1;
    wait_idle(0, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL both_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL both_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b11) $display("FAIL both_cause got %b exp 11", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL both_count got %0d exp %0d", reset_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_stuck_timeout();
    int lo, st;
    bit to;
    wdt_timeout = 1'b1;
    @(negedge clk);
    if (CNT_EN) exp_count = exp_count + 8'd1;
    wait_idle(40, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL stuck_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL stuck_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (st != 40) $display("FAIL stuck_stop got %0d exp 40", st); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL stuck_count got %0d exp %0d", reset_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_sw_during_assert();
    int lo, st;
    bit to;
    cause_clear = 1'b1;
    @(negedge clk);
    cause_clear = 1'b0;
    check_cnt++; if (reset_cause !== 2'b00) $display("FAIL clr_cause got %b exp 00", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== 8'd0) $display("FAIL clr_count got %0d exp 0", reset_count); else pass_cnt++;
    exp_count = 8'd0;
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_idle(0, 5, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL swa_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL swa_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (st != 4) $display("FAIL swa_stop got %0d exp 4", st); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b10) $display("FAIL swa_cause got %b exp 10", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL swa_count got %0d exp %0d", reset_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_clear_vs_set();
    int lo, st;
    bit to;
    wdt_timeout = 1'b1;
    cause_clear = 1'b1;
    @(negedge clk);
    wdt_timeout = 1'b0;
    cause_clear = 1'b0;
    exp_count = CNT_EN ? 8'd1 : 8'd0;
    check_cnt++; if (reset_cause !== 2'b01) $display("FAIL cvs_cause got %b exp 01", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL cvs_count got %0d exp %0d", reset_count, exp_count); else pass_cnt++;
    cause_clear = 1'b1;
    @(negedge clk);
    cause_clear = 1'b0;
    exp_count = 8'd0;
    check_cnt++; if (reset_cause !== 2'b00) $display("FAIL clr_in_assert_cause got %b exp 00", reset_cause); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL clr_in_assert_count got %0d exp 0", reset_count); else pass_cnt++;
    wait_idle(0, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL cvs_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 15) $display("FAIL cvs_low_remaining got %0d exp 15", lo); else pass_cnt++;
  endtask

  task automatic test_reset_mid_assert();
    int lo, st;
    bit to;
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_cnt++; if (sys_reset_n !== 1'b0 || busy !== 1'b1) $display("FAIL mid_rst_outs got %b%b exp 01", sys_reset_n, busy); else pass_cnt++;
    check_cnt++; if (reset_cause !== 2'b00) $display("FAIL mid_rst_cause got %b exp 00", reset_cause); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 8'd0;
    wait_idle(0, -1, lo, st, to);
    check_cnt++; if (to !== 1'b0) $display("FAIL mid_rst_bound got %b exp 0", to); else pass_cnt++;
    check_cnt++; if (lo != 16) $display("FAIL mid_rst_low got %0d exp 16", lo); else pass_cnt++;
    check_cnt++; if (st != 4) $display("FAIL mid_rst_stop got %0d exp 4", st); else pass_cnt++;
    check_cnt++; if (reset_count !== exp_count) $display("FAIL mid_rst_count got %0d exp 0", reset_count); else pass_cnt++;
  endtask

`ifdef WDT_RESET_COUNT_EN
  task automatic test_count_saturate();
    int lo, st, n_to;
    bit to;
    n_to = 0;
    for (int i = 1; i <= 300; i++) begin
      wdt_timeout = 1'b1;
      @(negedge clk);
      wait_idle(0, -1, lo, st, to);
      if (to) n_to++;
      if (i == 254) begin
        check_cnt++; if (reset_count !== 8'hfe) $display("FAIL cnt_254 got %0h exp fe", reset_count); else pass_cnt++;
      end
    end
    check_cnt++; if (n_to != 0) $display("FAIL cnt_bound got %0d exp 0", n_to); else pass_cnt++;
    check_cnt++; if (reset_count !== 8'hff) $display("FAIL cnt_sat got %0h exp ff", reset_count); else pass_cnt++;
  endtask
`endif

  initial begin
    reset_n      = 1'b0;
    wdt_timeout  = 1'b0;
    sw_reset_req = 1'b0;
    cause_clear  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_wdt_timeout();
    test_both_triggers();
    test_stuck_timeout();
    test_sw_during_assert();
    test_clear_vs_set();
    test_reset_mid_assert();
`ifdef WDT_RESET_COUNT_EN
    test_count_saturate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
